// File: rtl/led_scan_ctrl_pkg.sv
// led_scan_ctrl_pkg: shared segment codes, register map and bit positions for the LED scan controller
package led_scan_ctrl_pkg;
  typedef enum logic {B2B_IDLE, B2B_RUN} b2b_state_t;
  localparam logic [31:0] DATA_OFS = 32'h0;
  localparam logic [31:0] CTRL_OFS = 32'h4;
  localparam logic [31:0] STAT_OFS = 32'h8;
  localparam logic [31:0] CTRL_RST = 32'h0000_00F4;
  localparam int MODE_BIT  = 0;
  localparam int BLANK_BIT = 1;
  localparam int EN_BIT    = 2;
  localparam int DUTY_LSB  = 4;
  localparam int DP_LSB    = 8;
  localparam int BUSY_BIT  = 0;
  localparam int OVF_BIT   = 1;
  localparam int IDX_LSB   = 8;
  localparam logic [7:0] LED_0 = 8'hFC;
  localparam logic [7:0] LED_1 = 8'h60;
  localparam logic [7:0] LED_2 = 8'hDA;
  localparam logic [7:0] LED_3 = 8'hF2;
  localparam logic [7:0] LED_4 = 8'h66;
  localparam logic [7:0] LED_5 = 8'hB6;
  localparam logic [7:0] LED_6 = 8'hBE;
  localparam logic [7:0] LED_7 = 8'hE0;
  localparam logic [7:0] LED_8 = 8'hFE;
  localparam logic [7:0] LED_9 = 8'hF6;
  localparam logic [7:0] LED_A = 8'hEE;
  localparam logic [7:0] LED_B = 8'h3E;
  localparam logic [7:0] LED_C = 8'h9C;
  localparam logic [7:0] LED_D = 8'h7A;
  localparam logic [7:0] LED_E = 8'h9E;
  localparam logic [7:0] LED_F = 8'h8E;
  localparam logic [15:0][7:0] SEG_LUT = {LED_F, LED_E, LED_D, LED_C, LED_B, LED_A, LED_9, LED_8,
                                          LED_7, LED_6, LED_5, LED_4, LED_3, LED_2, LED_1, LED_0};
  function automatic logic [7:0] seg_code(input logic [3:0] v);
    return SEG_LUT[v];
  endfunction
endpackage

// File: rtl/led_scan_ctrl_bin2bcd_seq.sv
// led_scan_ctrl_bin2bcd_seq: 32-bit binary to 10-digit BCD, one shift-add-3 step per clk
module led_scan_ctrl_bin2bcd_seq
  import led_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] bin,
  output logic [39:0] bcd,
  output logic        busy,
  output logic        done
);
  b2b_state_t st, st_n;
  logic [5:0] cnt, cnt_n;
  logic [71:0] sh, sh_n, adj;
  assign bcd = sh[71:32];
  assign busy = st == B2B_RUN;
  // a start in the final cycle restarts, so the stale result is not published
  assign done = busy && cnt == 6'd32 && !start;
  always_ff @(posedge clk) begin
    if (RST) begin
      st <= B2B_IDLE;
      cnt <= '0;
      sh <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      sh <= sh_n;
    end
  end
  always_comb begin
    adj = sh;
    for (int i = 0; i < 10; i++)
      adj[32+4*i +: 4] = sh[32+4*i +: 4] >= 4'd5 ? sh[32+4*i +: 4] + 4'd3 : sh[32+4*i +: 4];
    st_n = st;
    cnt_n = cnt;
    sh_n = sh;
    if (start) begin
      st_n = B2B_RUN;
      cnt_n = '0;
      sh_n = {40'd0, bin};
    end else if (busy && cnt == 6'd32) begin
      st_n = B2B_IDLE;
    end else if (busy) begin
      cnt_n = cnt + 6'd1;
      sh_n = adj << 1;
    end
  end
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: bus-mapped N-digit multiplexed 7-segment controller with hex/decimal,
// leading-zero blanking, per-digit DP and PWM brightness
module led_scan_ctrl
  import led_scan_ctrl_pkg::*;
#(
  parameter int          DIGITS     = 4,
  parameter logic [31:0] SCAN_COUNT = 32'd50000,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [31:0]       ADD,
  input  logic [31:0]       DAT_I,
  input  logic              Wr,
  input  logic [3:0]        BE,
  output logic [31:0]       DAT_O,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] sel
);
  localparam logic [31:0] CTRL_MASK = 32'h0000_00F7 | (((32'd1 << DIGITS) - 32'd1) << DP_LSB);
  localparam logic [31:0] DIGIT_MASK = DIGITS == 8 ? 32'hFFFF_FFFF : (32'd1 << (4 * DIGITS)) - 32'd1;
  logic [31:0] data, ctrl, status, wmask, data_w, ctrl_w, src, count;
  logic [39:0] bcd_res, bcd_disp;
  logic [2:0] idx;
  logic [3:0] pwm, cur, duty;
  logic [7:0] dp, code, seg_n;
  logic wr_data, wr_ctrl, start, busy, done, ovf, blank, lit;
  logic [DIGITS-1:0] sel_n;
  assign wmask = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
  assign data_w = (DAT_I & wmask) | (data & ~wmask);
  assign ctrl_w = ((DAT_I & wmask) | (ctrl & ~wmask)) & CTRL_MASK;
  assign wr_data = Wr && ADD == BASE_ADDR + DATA_OFS;
  assign wr_ctrl = Wr && ADD == BASE_ADDR + CTRL_OFS;
  assign start = wr_data || (wr_ctrl && !ctrl[MODE_BIT] && ctrl_w[MODE_BIT]);
  led_scan_ctrl_bin2bcd_seq u_b2b (
    .clk  (clk),
    .RST  (RST),
    .start(start),
    .bin  (wr_data ? data_w : data),
    .bcd  (bcd_res),
    .busy (busy),
    .done (done)
  );
  always_ff @(posedge clk) begin
    if (RST) begin
      data <= '0;
      ctrl <= CTRL_RST;
      bcd_disp <= '0;
      count <= SCAN_COUNT;
      idx <= '0;
      pwm <= '0;
      seg <= '0;
      sel <= '0;
    end else begin
      if (wr_data) data <= data_w;
      if (wr_ctrl) ctrl <= ctrl_w;
      if (done) bcd_disp <= bcd_res;
      count <= count == 32'd0 ? SCAN_COUNT : count - 32'd1;
      if (count == 32'd0) idx <= idx == 3'(DIGITS - 1) ? 3'd0 : idx + 3'd1;
      pwm <= pwm + 4'd1;
      seg <= seg_n;
      sel <= sel_n;
    end
  end
  // the displayed BCD only changes on done, so the display never tears mid-conversion
  always_comb begin
    duty = ctrl[DUTY_LSB +: 4];
    dp = ctrl[DP_LSB +: 8];
    src = ctrl[MODE_BIT] ? bcd_disp[31:0] : data;
    cur = src[{idx, 2'b00} +: 4];
    blank = ctrl[BLANK_BIT] && idx != 3'd0 && ((src & DIGIT_MASK) >> {idx, 2'b00}) == 32'd0;
    code = seg_code(cur);
    seg_n = blank ? 8'h00 : {code[7:1], dp[idx]};
    lit = ctrl[EN_BIT] && (duty == 4'hF || pwm < duty);
    sel_n = lit ? DIGITS'(1) << idx : '0;
    ovf = |(bcd_disp >> (4 * DIGITS));
    status = '0;
    status[BUSY_BIT] = busy;
    status[OVF_BIT] = ovf;
    status[IDX_LSB +: 3] = idx;
    DAT_O = ADD == BASE_ADDR + DATA_OFS ? data :
            ADD == BASE_ADDR + CTRL_OFS ? ctrl :
            ADD == BASE_ADDR + STAT_OFS ? status : 32'd0;
  end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: table-driven register vectors plus directed display/conversion sequences
module tb_led_scan_ctrl;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] CTRL = BASE + 32'h4;
  localparam logic [31:0] STAT = BASE + 32'h8;
  typedef struct {
    logic        wr;
    logic [31:0] add;
    logic [31:0] dat;
    logic [3:0]  be;
    logic [31:0] rdadd;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst, wr_en;
  logic [31:0] add, dat_i, dat_o;
  logic [3:0] be, sel;
  logic [7:0] seg;
  int nvec = 0;
  int nfail = 0;
  vec_t tv [9];
  led_scan_ctrl #(.DIGITS(4), .SCAN_COUNT(32'd3), .BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .RST  (rst),
    .ADD  (add),
    .DAT_I(dat_i),
    .Wr   (wr_en),
    .BE   (be),
    .DAT_O(dat_o),
    .seg  (seg),
    .sel  (sel)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    add = a;
    dat_i = d;
    be = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    add = a;
    #1;
    v = dat_o;
  endtask
  task automatic get_seg(input int k, output logic [7:0] s);
    int i;
    s = '0;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sel == 4'(1 << k)) break;
    end
    if (i == 64) chk($sformatf("sel_timeout_d%0d", k), 32'd0, 32'd1);
    else s = seg;
  endtask
  task automatic digits(input string nm, input logic [31:0] e);
    logic [7:0] s;
    for (int k = 0; k < 4; k++) begin
      get_seg(k, s);
      chk($sformatf("%s_d%0d", nm, k), {24'd0, s}, {24'd0, e[8*k +: 8]});
    end
  endtask
  // counts cycles with busy=1; optionally checks the old digits stay on display meanwhile
  task automatic count_busy(output int n, input bit chk_old, input logic [31:0] old);
    n = 0;
    add = STAT;
    #1;
    while (dat_o[0] && n < 100) begin
      n++;
      if (chk_old)
        for (int k = 0; k < 4; k++)
          if (sel[k]) chk($sformatf("old_d%0d_c%0d", k, n), {24'd0, seg}, {24'd0, old[8*k +: 8]});
      @(negedge clk);
      #1;
    end
  endtask
  task automatic count_sel(input string nm, input int exp_on);
    int on, segs;
    on = 0;
    segs = 0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (sel != 4'd0) on++;
      if (seg != 8'd0) segs++;
    end
    chk(nm, on, exp_on);
    chk({nm, "_seg_driven"}, 32'(segs > 0), 32'd1);
  endtask
  initial begin
    logic [31:0] v;
    int n;
    tv[0] = '{1'b1, BASE,          32'h0000_BEEF, 4'b1111, BASE,          32'h0000_BEEF};
    tv[1] = '{1'b1, BASE,          32'h0000_0012, 4'b0001, BASE,          32'h0000_BE12};
    tv[2] = '{1'b1, BASE,          32'hAABB_CCDD, 4'b1010, BASE,          32'hAA00_CC12};
    tv[3] = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 4'b1111, BASE + 32'hC,  32'h0000_0000};
    tv[4] = '{1'b1, 32'h0,         32'hFFFF_FFFF, 4'b1111, BASE,          32'hAA00_CC12};
    tv[5] = '{1'b1, CTRL,          32'hFFFF_FFFF, 4'b0010, CTRL,          32'h0000_0FF4};
    tv[6] = '{1'b1, CTRL,          32'h0000_00F4, 4'b1111, CTRL,          32'h0000_00F4};
    tv[7] = '{1'b1, CTRL,          32'hFFFF_FFFF, 4'b1100, CTRL,          32'h0000_00F4};
    tv[8] = '{1'b1, BASE,          32'h0000_BEEF, 4'b1111, BASE,          32'h0000_BEEF};
    rst = 1'b1;
    wr_en = 1'b0;
    add = BASE;
    dat_i = '0;
    be = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_seg", {24'd0, seg}, 32'd0);
    bus_rd(BASE, v); chk("rst_data", v, 32'd0);
    bus_rd(CTRL, v); chk("rst_ctrl", v, 32'h0000_00F4);
    bus_rd(STAT, v); chk("rst_stat", v, 32'd0);
    rst = 1'b0;
    add = STAT;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("scan_sel%0d", i), {28'd0, sel}, 32'(1 << ((i / 4) % 4)));
      chk($sformatf("scan_seg%0d", i), {24'd0, seg}, 32'h0000_00FC);
      chk($sformatf("scan_idx%0d", i), {29'd0, dat_o[10:8]}, 32'(((i + 1) / 4) % 4));
    end
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (tv[i].wr) bus_wr(tv[i].add, tv[i].dat, tv[i].be);
      bus_rd(tv[i].rdadd, v);
      chk($sformatf("reg%0d", i), v, tv[i].exp);
      @(negedge clk);
    end
    digits("hex_beef", {8'h3E, 8'h9E, 8'h9E, 8'h8E});
    bus_wr(BASE, 32'h0000_0012, 4'b0001);
    bus_rd(BASE, v); chk("data_be12", v, 32'h0000_BE12);
    digits("hex_be12", {8'h3E, 8'h9E, 8'h60, 8'hDA});
    @(negedge clk);
    bus_wr(CTRL, 32'h0000_00F5, 4'b1111);
    count_busy(n, 1'b0, 32'd0);
    chk("busy_ctrl_start", n, 33);
    repeat (2) @(negedge clk);
    digits("dec_48658", {8'hFE, 8'hBE, 8'hB6, 8'hFE});
    bus_rd(STAT, v); chk("ovf_48658", v & 32'd3, 32'd2);
    @(negedge clk);
    bus_wr(BASE, 32'd4321, 4'b1111);
    count_busy(n, 1'b1, {8'hFE, 8'hBE, 8'hB6, 8'hFE});
    chk("busy_4321", n, 33);
    repeat (2) @(negedge clk);
    digits("dec_4321", {8'h66, 8'hF2, 8'hDA, 8'h60});
    bus_rd(STAT, v); chk("ovf_4321", v & 32'd3, 32'd0);
    @(negedge clk);
    bus_wr(BASE, 32'd999999, 4'b1111);
    repeat (10) @(negedge clk);
    bus_wr(BASE, 32'd123456, 4'b1111);
    count_busy(n, 1'b0, 32'd0);
    chk("busy_restart", n, 33);
    repeat (2) @(negedge clk);
    digits("dec_123456", {8'hF2, 8'h66, 8'hB6, 8'hBE});
    bus_rd(STAT, v); chk("ovf_123456", v & 32'd3, 32'd2);
    @(negedge clk);
    bus_wr(CTRL, 32'h0000_00F7, 4'b1111);
    bus_wr(BASE, 32'd7, 4'b1111);
    count_busy(n, 1'b0, 32'd0);
    chk("busy_7", n, 33);
    repeat (2) @(negedge clk);
    digits("blank_7", {8'h00, 8'h00, 8'h00, 8'hE0});
    bus_rd(STAT, v); chk("ovf_7", v & 32'd3, 32'd0);
    @(negedge clk);
    bus_wr(CTRL, 32'h0000_05F7, 4'b1111);
    digits("dp_blank", {8'h00, 8'h00, 8'h00, 8'hE1});
    bus_wr(CTRL, 32'h0000_05F5, 4'b1111);
    digits("dp_noblank", {8'hFC, 8'hFD, 8'hFC, 8'hE1});
    bus_wr(CTRL, 32'h0000_0005, 4'b1111);
    count_sel("duty0_on", 0);
    bus_wr(CTRL, 32'h0000_0085, 4'b1111);
    count_sel("duty8_on", 16);
    bus_wr(CTRL, 32'h0000_00F1, 4'b1111);
    count_sel("disabled_on", 0);
    bus_wr(BASE, 32'd99, 4'b1111);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_rd(STAT, v); chk("rstbusy_stat", v, 32'd0);
    bus_rd(CTRL, v); chk("rstbusy_ctrl", v, 32'h0000_00F4);
    bus_rd(BASE, v); chk("rstbusy_data", v, 32'd0);
    chk("rstbusy_sel", {28'd0, sel}, 32'd0);
    chk("rstbusy_seg", {24'd0, seg}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    bus_rd(STAT, v); chk("after_abort_stat", v & 32'd3, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
